// File: rtl/act_pipe_if.sv
// act_pipe_if: valid/ready input and output channels of the activation pipeline.
// The slave modport is the pipeline's view of the bus; master is the driver/consumer side.
interface act_pipe_if #(
    parameter int NUM_CH          = 4,
    parameter int ACC_WIDTH       = 32,
    parameter int UINT_DATA_WIDTH = 8
);
    logic                              in_valid;
    logic                              in_ready;
    logic [NUM_CH*ACC_WIDTH-1:0]       in_data;
    logic                              in_mode;
    logic                              out_valid;
    logic                              out_ready;
    logic [NUM_CH*UINT_DATA_WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/act_pipe.sv
// act_pipe: two-stage activation (ReLU-clamp or signed zero-point) over NUM_CH accumulators.
// Define ACT_PIPE_ROUND_EN to round half up before the scale-down shift.
module act_pipe #(
    parameter int NUM_CH           = 4,
    parameter int ACC_WIDTH        = 32,
    parameter int UINT_DATA_WIDTH  = 8,
    parameter int WB_LOG2_SCALE    = 7,
    parameter int LOG2_RELU_FACTOR = 1,
    parameter int SAT_CNT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    act_pipe_if.slave                bus,
    input  logic                     sat_clr,
    output logic [SAT_CNT_WIDTH-1:0] sat_cnt
);
    localparam int LOG2_SCALE = WB_LOG2_SCALE + LOG2_RELU_FACTOR;
    localparam int IW         = ACC_WIDTH + 1;
    localparam int UW         = UINT_DATA_WIDTH;
    localparam int SVW        = UW + LOG2_SCALE;
    localparam int SW         = SAT_CNT_WIDTH + $clog2(NUM_CH + 1);

    localparam logic signed [IW-1:0] C_ONE   = {{(IW-1){1'b0}}, 1'b1};
    localparam logic signed [IW-1:0] C_U_MAX = (C_ONE <<< (UW + LOG2_SCALE)) - C_ONE;
    localparam logic signed [IW-1:0] C_S_MAX = (C_ONE <<< (UW - 1)) - C_ONE;
    localparam logic signed [IW-1:0] C_S_MIN = -(C_ONE <<< (UW - 1));
`ifdef ACT_PIPE_ROUND_EN
    localparam logic signed [IW-1:0] C_RND   = C_ONE <<< (LOG2_SCALE - 1);
`endif
    localparam logic [UW-1:0]        C_ZP      = {1'b1, {(UW-1){1'b0}}};
    localparam logic [SW-1:0]        C_CNT_MAX = {{(SW-SAT_CNT_WIDTH){1'b0}}, {SAT_CNT_WIDTH{1'b1}}};

    function automatic logic [SW-1:0] f_popcount(input logic [NUM_CH-1:0] v);
        logic [SW-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc = acc + {{(SW-1){1'b0}}, v[i]};
        end
        return acc;
    endfunction

    logic                     w_s2_ready;
    logic                     w_s1_ready;
    logic                     w_in_fire;
    logic [NUM_CH-1:0]        w_sat_ev;
    logic [SVW-1:0]           w_clamp [NUM_CH];
    logic [NUM_CH*UW-1:0]     w_s2_data;
    logic [SW-1:0]            w_cnt_sum;
    logic [SAT_CNT_WIDTH-1:0] w_cnt_next;

    logic                     r_s1_valid;
    logic                     r_s1_mode;
    logic [SVW-1:0]           r_s1_val [NUM_CH];
    logic                     r_out_valid;
    logic [NUM_CH*UW-1:0]     r_out_data;
    logic [SAT_CNT_WIDTH-1:0] r_sat_cnt;

    assign w_s2_ready    = !r_out_valid || bus.out_ready;
    assign w_s1_ready    = !r_s1_valid || w_s2_ready;
    assign w_in_fire     = bus.in_valid && w_s1_ready;
    assign bus.in_ready  = w_s1_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign sat_cnt       = r_sat_cnt;

    // S1 holds, per channel, either the clamped ReLU value (pre-shift) or the clamped signed byte.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [IW-1:0] w_x;
        logic signed [IW-1:0] w_sh;
        logic [SVW-1:0]       w_val;
        logic                 w_ev;

        // Range detect and clamp of one channel.
        always_comb begin
            w_x = {bus.in_data[k*ACC_WIDTH+ACC_WIDTH-1], bus.in_data[k*ACC_WIDTH +: ACC_WIDTH]};
`ifdef ACT_PIPE_ROUND_EN
            w_x = w_x + C_RND;
`endif
            w_sh  = w_x >>> LOG2_SCALE;
            w_val = '0;
            w_ev  = 1'b0;
            if (bus.in_mode == 1'b0) begin
                if (w_x[IW-1]) begin
                    w_val = '0;
                    w_ev  = 1'b0;
                end else if (w_x > C_U_MAX) begin
                    w_val = C_U_MAX[SVW-1:0];
                    w_ev  = 1'b1;
                end else begin
                    w_val = w_x[SVW-1:0];
                    w_ev  = 1'b0;
                end
            end else begin
                if (w_sh > C_S_MAX) begin
                    w_val = {{LOG2_SCALE{1'b0}}, C_S_MAX[UW-1:0]};
                    w_ev  = 1'b1;
                end else if (w_sh < C_S_MIN) begin
                    w_val = {{LOG2_SCALE{1'b0}}, C_S_MIN[UW-1:0]};
                    w_ev  = 1'b1;
                end else begin
                    w_val = {{LOG2_SCALE{1'b0}}, w_sh[UW-1:0]};
                    w_ev  = 1'b0;
                end
            end
        end

        assign w_clamp[k]  = w_val;
        assign w_sat_ev[k] = w_ev;
    end

    // S2 datapath: scale-down for ReLU, zero-point offset (MSB flip) for signed mode.
    always_comb begin
        w_s2_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_s1_mode == 1'b0) begin
                w_s2_data[k*UW +: UW] = r_s1_val[k][LOG2_SCALE +: UW];
            end else begin
                w_s2_data[k*UW +: UW] = r_s1_val[k][UW-1:0] + C_ZP;
            end
        end
    end

    // Saturating add of this beat's clamp events.
    always_comb begin
        w_cnt_sum = {{(SW-SAT_CNT_WIDTH){1'b0}}, r_sat_cnt} + f_popcount(w_sat_ev);
        if (w_cnt_sum > C_CNT_MAX) begin
            w_cnt_next = {SAT_CNT_WIDTH{1'b1}};
        end else begin
            w_cnt_next = w_cnt_sum[SAT_CNT_WIDTH-1:0];
        end
    end

    // Stage 1 register: captures mode and clamped channels on every accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_val   <= '{default: '0};
        end else if (w_s1_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_mode <= bus.in_mode;
                r_s1_val  <= w_clamp;
            end
        end
    end

    // Stage 2 / output register: holds steady while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_s2_data;
            end
        end
    end

    // Saturation counter; clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (w_in_fire) begin
            r_sat_cnt <= w_cnt_next;
        end
    end
endmodule

// File: tb/tb_act_pipe.sv
// tb_act_pipe: directed and randomized checks of act_pipe against a behavioural scoreboard.
// A second instance with a 4-bit saturation counter shares the same stimulus.
module tb_act_pipe;
    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int UW  = 8;
    localparam int LS  = 8;
    localparam int OW  = NCH * UW;
    localparam longint U_MAX = (64'sd1 <<< (UW + LS)) - 64'sd1;
    localparam longint S_MAX = (64'sd1 <<< (UW - 1)) - 64'sd1;
    localparam longint S_MIN = -(64'sd1 <<< (UW - 1));

    logic        clk;
    logic        rst;
    logic        sat_clr;
    logic [15:0] sat_cnt;
    logic [3:0]  sat_cnt4;

    act_pipe_if #(.NUM_CH(NCH), .ACC_WIDTH(AW), .UINT_DATA_WIDTH(UW)) ifa ();
    act_pipe_if #(.NUM_CH(NCH), .ACC_WIDTH(AW), .UINT_DATA_WIDTH(UW)) ifb ();

    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.in_data   = ifa.in_data;
    assign ifb.in_mode   = ifa.in_mode;
    assign ifb.out_ready = ifa.out_ready;

    act_pipe u_dut (
        .clk(clk), .rst(rst), .bus(ifa.slave), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );
    act_pipe #(.SAT_CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(ifb.slave), .sat_clr(sat_clr), .sat_cnt(sat_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [OW-1:0] exp_q [$];
    int            sat_m   = 0;
    int            sat4_m  = 0;
    logic [OW-1:0] last_out = '0;
    logic          last_ov  = 1'b0;
    logic          last_fi  = 1'b0;
    logic          held     = 1'b0;
    logic [OW-1:0] held_data = '0;
    int            delivered = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: per channel, expected output byte and clamp event count, from plain integer arithmetic.
    function automatic void ref_beat(input logic [NCH*AW-1:0] d, input logic m,
                                     output logic [OW-1:0] y, output int nev);
        longint v, r;
        longint yk;
        nev = 0;
        y   = '0;
        for (int k = 0; k < NCH; k++) begin
            v = $signed(d[k*AW +: AW]);
`ifdef ACT_PIPE_ROUND_EN
            v = v + (64'sd1 <<< (LS - 1));
`endif
            if (m == 1'b0) begin
                r = (v < 0) ? 64'sd0 : v;
                if (r > U_MAX) begin
                    r = U_MAX;
                    nev++;
                end
                yk = r / (64'sd1 <<< LS);
            end else begin
                r = v >>> LS;
                if (r > S_MAX) begin
                    r = S_MAX;
                    nev++;
                end else if (r < S_MIN) begin
                    r = S_MIN;
                    nev++;
                end
                yk = r - S_MIN;
            end
            y[k*UW +: UW] = yk[UW-1:0];
        end
    endfunction

    // One clock: sample before the edge, update the model at the edge, check counters after it.
    task automatic tick();
        logic          fi, fo, stall, iclr, irst, imode;
        logic [OW-1:0] od, e;
        logic [NCH*AW-1:0] idata;
        int            nev;
        #1;
        fi    = ifa.in_valid && ifa.in_ready;
        fo    = ifa.out_valid && ifa.out_ready;
        od    = ifa.out_data;
        idata = ifa.in_data;
        imode = ifa.in_mode;
        iclr  = sat_clr;
        irst  = rst;
        last_ov = ifa.out_valid;
        stall = ifa.out_valid && !ifa.out_ready;
        if (!irst) begin
            check_eq("in_ready", ifa.in_ready, !(exp_q.size() == 2 && !ifa.out_ready));
            if (exp_q.size() == 0) check_eq("idle_out_valid", ifa.out_valid, 1'b0);
            if (held) check_eq("stall_hold", od, held_data);
        end
        @(posedge clk);
        if (irst) begin
            exp_q.delete();
            sat_m   = 0;
            sat4_m  = 0;
            held    = 1'b0;
            last_fi = 1'b0;
        end else begin
            if (fo) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", od, e);
                    last_out = od;
                    delivered++;
                end
            end
            if (fi) begin
                ref_beat(idata, imode, e, nev);
                exp_q.push_back(e);
            end else begin
                nev = 0;
            end
            if (iclr) begin
                sat_m  = 0;
                sat4_m = 0;
            end else begin
                sat_m  = (sat_m + nev > 65535) ? 65535 : sat_m + nev;
                sat4_m = (sat4_m + nev > 15) ? 15 : sat4_m + nev;
            end
            held      = stall;
            held_data = od;
            last_fi   = fi;
        end
        @(negedge clk);
        check_eq("sat_cnt", sat_cnt, sat_m);
        check_eq("sat_cnt4", sat_cnt4, sat4_m);
    endtask

    task automatic drain();
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic set_beat(input logic [31:0] c0, input logic [31:0] c1,
                            input logic [31:0] c2, input logic [31:0] c3, input logic m);
        ifa.in_data  = {c3, c2, c1, c0};
        ifa.in_mode  = m;
        ifa.in_valid = 1'b1;
    endtask

    function automatic logic [31:0] rand_x();
        logic [31:0] x;
        case ($urandom_range(0, 4))
            0:       x = $urandom();
            1:       x = $urandom_range(0, 140000) - 32'd70000;
            2:       x = 32'd65279 + $urandom_range(0, 768);
            3:       x = (($urandom_range(0, 1) == 0) ? 32'd32512 : -32'd33024) + $urandom_range(0, 512);
            default: x = $urandom_range(0, 1000) - 32'd500;
        endcase
        return x;
    endfunction

    initial begin
        rst = 1'b1;
        sat_clr = 1'b0;
        ifa.in_valid = 1'b0;
        ifa.in_data = '0;
        ifa.in_mode = 1'b0;
        ifa.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_eq("rst_out_valid", ifa.out_valid, 1'b0);
        check_eq("rst_out_data", ifa.out_data, 32'h0);
        check_eq("rst_in_ready", ifa.in_ready, 1'b1);
        check_eq("rst_sat", sat_cnt, 16'd0);

        // Mode 0 directed vector plus latency.
        set_beat(32'd32768, 32'd65535, 32'd70000, -32'sd5, 1'b0);
        tick();
        ifa.in_valid = 1'b0;
        tick();
        check_eq("lat_cycle1", last_ov, 1'b0);
        tick();
        check_eq("lat_cycle2", last_ov, 1'b1);
        check_eq("m0_bytes", last_out, 32'h00FFFF80);
        check_eq("m0_sat", sat_cnt, 16'd1);

        // Mode 1 directed vector.
        set_beat(-32'sd256, 32'd0, 32'h7FFFFFFF, 32'h80000000, 1'b1);
        tick();
        drain();
        check_eq("m1_bytes", last_out, 32'h00FF807F);
        check_eq("m1_sat", sat_cnt, 16'd3);

        // Rounding boundaries.
        set_beat(32'd383, 32'd384, 32'd0, 32'd0, 1'b0);
        tick();
        drain();
`ifdef ACT_PIPE_ROUND_EN
        check_eq("rnd_m0", last_out, 32'h00000201);
`else
        check_eq("rnd_m0", last_out, 32'h00000101);
`endif
        set_beat(-32'sd129, -32'sd128, 32'd0, 32'd0, 1'b1);
        tick();
        drain();
`ifdef ACT_PIPE_ROUND_EN
        check_eq("rnd_m1", last_out, 32'h8080807F);
`else
        check_eq("rnd_m1", last_out, 32'h80807F7F);
`endif

        // Backpressure stream with out_ready pattern 1,0,0,1.
        begin
            int i, t, d0;
            i = 0;
            d0 = delivered;
            for (t = 0; t < 100 && (i < 8 || exp_q.size() != 0); t++) begin
                ifa.out_ready = (t % 4 == 0) || (t % 4 == 3);
                if (i < 8) begin
                    set_beat((i*4+1)*256 + i, (i*4+2)*256 + i, (i*4+3)*256 + i, (i*4+4)*256 + i, 1'b0);
                end else begin
                    ifa.in_valid = 1'b0;
                end
                tick();
                if (last_fi) i++;
            end
            check_eq("bp_sent", i, 8);
            check_eq("bp_delivered", delivered - d0, 8);
            check_eq("bp_last", last_out, 32'h201F1E1D);
        end
        drain();

        // sat_clr beats a coincident 3-event increment.
        set_beat(32'd0, 32'd70000, 32'd70000, 32'd70000, 1'b0);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        ifa.in_valid = 1'b0;
        check_eq("clr_sat", sat_cnt, 16'd0);
        check_eq("clr_sat4", sat_cnt4, 4'd0);
        drain();

        // 20 fully saturated beats: narrow counter pins at 15.
        begin
            int n;
            n = 0;
            for (int t = 0; t < 60 && n < 20; t++) begin
                set_beat(32'd70000, 32'd70000, 32'd70000, 32'd70000, 1'b0);
                tick();
                if (last_fi) n++;
            end
            ifa.in_valid = 1'b0;
            check_eq("satur_beats", n, 20);
            check_eq("satur_cnt4", sat_cnt4, 4'd15);
            check_eq("satur_cnt16", sat_cnt, 16'd80);
        end
        drain();

        // Reset with two beats in flight.
        ifa.out_ready = 1'b0;
        set_beat(32'd70000, 32'd1000, 32'd2000, 32'd3000, 1'b0);
        tick();
        set_beat(32'd4000, 32'd70000, 32'd5000, 32'd6000, 1'b0);
        tick();
        check_eq("flight_depth", exp_q.size(), 2);
        ifa.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifa.out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            check_eq("post_rst_ov", last_ov, 1'b0);
        end
        check_eq("post_rst_sat", sat_cnt, 16'd0);
        check_eq("post_rst_in_ready", ifa.in_ready, 1'b1);

        // Randomized traffic with random stalls, modes and clears.
        for (int n = 0; n < 400; n++) begin
            if (!ifa.in_valid || last_fi) begin
                ifa.in_valid = ($urandom_range(0, 3) != 0);
                ifa.in_mode  = $urandom_range(0, 1);
                for (int k = 0; k < NCH; k++) ifa.in_data[k*AW +: AW] = rand_x();
            end
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            sat_clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        sat_clr = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
